// File: rtl/fx2_cmd_responder.sv
// Host command responder: decodes register read/write packets from the FX2
// command byte stream, drives the register bus and returns a framed reply.
module fx2_cmd_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CMD_TIMEOUT = 1024
) (
  input  logic              fx2_clk,
  input  logic              reset_n,
  input  logic [7:0]        cmd,
  input  logic              cmd_wr,
  output logic [7:0]        reply,
  output logic              reply_rdy,
  input  logic              reply_ack,
  output logic              reply_end,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NB + 2);
  localparam int unsigned NSLOT = 1 << IDX_W;
  localparam int unsigned TO_W  = $clog2(CMD_TIMEOUT + 1);

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] ST_RD_OK  = 8'h30;
  localparam logic [7:0] ST_WR_OK  = 8'h31;
  localparam logic [7:0] ST_BADOP  = 8'h6E;
  localparam logic [7:0] ST_TMOUT  = 8'h74;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_REG_RD,
    S_REG_WAIT,
    S_REG_WR,
    S_REPLY
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_op;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [7:0]         r_rx_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_ovr;
  logic [IDX_W-1:0]   r_ridx;
  logic [IDX_W-1:0]   r_last;
  logic [7:0]         r_rbuf [NSLOT];

  logic               w_rx_open;
  logic               w_timeout;
  logic               w_ack;
  logic               w_last;
  logic               w_ovr_evt;
  logic               w_data_done;
  logic               w_op_ok;
  logic [7:0]         w_ovr_bit;

  assign w_rx_open   = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign w_timeout   = w_rx_open && !cmd_wr && (r_to_cnt == TO_W'(CMD_TIMEOUT - 1));
  assign w_ack       = (r_state == S_REPLY) && reply_ack;
  assign w_last      = (r_ridx == r_last);
  assign w_ovr_evt   = cmd_wr && (r_state != S_IDLE) && !w_rx_open;
  assign w_data_done = cmd_wr && (r_rx_cnt == 8'(NB + 1));
  assign w_op_ok     = (cmd == OP_READ) || (cmd == OP_WRITE);
  assign w_ovr_bit   = {r_ovr, 7'b0};

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (cmd_wr) w_next = w_op_ok ? S_GET_ADDR : S_REPLY;
      S_GET_ADDR: begin
        if (cmd_wr)         w_next = (r_op == OP_READ) ? S_REG_RD : S_GET_DATA;
        else if (w_timeout) w_next = S_REPLY;
      end
      S_GET_DATA: begin
        if (w_data_done)    w_next = S_REG_WR;
        else if (w_timeout) w_next = S_REPLY;
      end
      S_REG_RD:   w_next = S_REG_WAIT;
      S_REG_WAIT: w_next = S_REPLY;
      S_REG_WR:   w_next = S_REPLY;
      S_REPLY:    if (w_ack && w_last) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rx_cnt <= '0;
      r_to_cnt <= '0;
      r_ovr    <= 1'b0;
      r_ridx   <= '0;
      r_last   <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) r_rbuf[i] <= '0;
    end else begin
      if (w_rx_open && !cmd_wr) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                      r_to_cnt <= '0;

      // Status byte latched its overrun bit at frame load; only clear what was reported.
      if (w_ack && (r_ridx == '0)) r_ovr <= w_ovr_evt || (r_ovr && !r_rbuf[0][7]);
      else if (w_ovr_evt)          r_ovr <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (cmd_wr) begin
            r_op     <= cmd;
            r_rx_cnt <= 8'd1;
            if (!w_op_ok) begin
              r_rbuf[0] <= ST_BADOP | w_ovr_bit;
              r_rbuf[1] <= cmd;
              r_last    <= IDX_W'(1);
              r_ridx    <= '0;
            end
          end
        end
        S_GET_ADDR, S_GET_DATA: begin
          if (cmd_wr) begin
            r_rx_cnt <= r_rx_cnt + 8'd1;
            if (r_state == S_GET_ADDR) r_addr  <= ADDR_W'(cmd);
            else                       r_wdata <= {cmd, r_wdata[DATA_W-1:8]};
          end else if (w_timeout) begin
            r_rbuf[0] <= ST_TMOUT | w_ovr_bit;
            r_rbuf[1] <= r_rx_cnt;
            r_last    <= IDX_W'(1);
            r_ridx    <= '0;
          end
        end
        S_REG_WAIT: begin
          r_rbuf[0] <= ST_RD_OK | w_ovr_bit;
          r_rbuf[1] <= 8'(r_addr);
          for (int unsigned i = 0; i < NB; i++) r_rbuf[i + 2] <= reg_rdata[8*i +: 8];
          r_last    <= IDX_W'(NB + 1);
          r_ridx    <= '0;
        end
        S_REG_WR: begin
          r_rbuf[0] <= ST_WR_OK | w_ovr_bit;
          r_rbuf[1] <= 8'(r_addr);
          r_last    <= IDX_W'(1);
          r_ridx    <= '0;
        end
        S_REPLY: begin
          if (w_ack) r_ridx <= w_last ? '0 : r_ridx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign reply_rdy = (r_state == S_REPLY);
  assign reply     = reply_rdy ? r_rbuf[r_ridx] : '0;
  assign reply_end = reply_rdy && w_last;
  assign reg_wr    = (r_state == S_REG_WR);
  assign reg_rd    = (r_state == S_REG_RD);
  assign busy      = (r_state != S_IDLE);
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;

endmodule
